// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode constants, instruction field layout and decode helpers
// Shared by the decode stage and the ALU. No ports.
package mips_pkg;

   localparam int DW_DEF   = 16;
   localparam int NREG_DEF = 8;

   // Instruction field positions (LSB of each field)
   localparam int OPC_LSB = 12;
   localparam int RD_LSB  = 9;
   localparam int RS1_LSB = 6;
   localparam int RS2_LSB = 3;
   localparam int IMM_LSB = 0;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_SLLI  = 4'hB;
   localparam logic [3:0] OP_ILL_C = 4'hC;
   localparam logic [3:0] OP_ILL_D = 4'hD;
   localparam logic [3:0] OP_SRLI  = 4'hE;
   localparam logic [3:0] OP_ILL_F = 4'hF;

   typedef struct packed {
      logic [3:0] opcode;
      logic [2:0] rd;
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic [5:0] imm6;
   } decoded_t;

   // imm6 overlaps rs2, so the fields cannot be a plain packed overlay
   function automatic decoded_t decode(input logic [15:0] ins);
      decoded_t d;
      d.opcode = ins[OPC_LSB +: 4];
      d.rd     = ins[RD_LSB  +: 3];
      d.rs1    = ins[RS1_LSB +: 3];
      d.rs2    = ins[RS2_LSB +: 3];
      d.imm6   = ins[IMM_LSB +: 6];
      return d;
   endfunction

   function automatic logic op_is_illegal(input logic [3:0] op);
      return (op == OP_ILL_C) || (op == OP_ILL_D) || (op == OP_ILL_F);
   endfunction

   function automatic logic op_uses_imm(input logic [3:0] op);
      return (op == OP_SLLI) || (op == OP_SRLI);
   endfunction

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - register file, two async read ports, one sync write port
// Ports: clk_i, rst_ni (sync, active-low); raddr1_i/rdata1_o, raddr2_i/rdata2_o
// async reads with write-first bypass; we_i/waddr_i/wdata_i sync write.
// r0 always reads zero and ignores writes.
module regfile
   import mips_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int NREG = NREG_DEF
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [2:0]    raddr1_i,
   input  logic [2:0]    raddr2_i,
   output logic [DW-1:0] rdata1_o,
   output logic [DW-1:0] rdata2_o,
   input  logic          we_i,
   input  logic [2:0]    waddr_i,
   input  logic [DW-1:0] wdata_i
);

   logic [DW-1:0] mem_q [NREG];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i && (waddr_i != 3'd0)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // The r0 test comes first so a write-back aimed at r0 is never bypassed
   assign rdata1_o = (raddr1_i == 3'd0)                 ? '0      :
                     (we_i && (waddr_i == raddr1_i))     ? wdata_i : mem_q[raddr1_i];
   assign rdata2_o = (raddr2_i == 3'd0)                 ? '0      :
                     (we_i && (waddr_i == raddr2_i))     ? wdata_i : mem_q[raddr2_i];

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: operand fetch, busy scoreboard, execute handoff
// Ports: clk, rst_n (sync, active-low); instr_valid/instr_ready/instr in;
// ex_valid/ex_ready with registered ex_aluctrl, ex_din1, ex_din2, ex_rd out;
// wb_en/wb_rd/wb_data write-back in; illegal one-cycle pulse out.
module id_stage
   import mips_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int NREG = NREG_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [15:0]   instr,
   output logic          ex_valid,
   input  logic          ex_ready,
   output logic [3:0]    ex_aluctrl,
   output logic [DW-1:0] ex_din1,
   output logic [DW-1:0] ex_din2,
   output logic [2:0]    ex_rd,
   input  logic          wb_en,
   input  logic [2:0]    wb_rd,
   input  logic [DW-1:0] wb_data,
   output logic          illegal
);

   decoded_t      dec;
   logic          is_nop, is_ill, is_imm, is_rtype;
   logic          hazard, accept, issue;
   logic [DW-1:0] rdata1, rdata2;

   logic [NREG-1:0] busy_q, busy_d;
   logic            ex_valid_q, ex_valid_d;
   logic [3:0]      ex_aluctrl_q, ex_aluctrl_d;
   logic [DW-1:0]   ex_din1_q, ex_din1_d;
   logic [DW-1:0]   ex_din2_q, ex_din2_d;
   logic [2:0]      ex_rd_q, ex_rd_d;
   logic            illegal_q, illegal_d;

   assign dec      = decode(instr);
   assign is_nop   = (dec.opcode == OP_NOP);
   assign is_ill   = op_is_illegal(dec.opcode);
   assign is_imm   = op_uses_imm(dec.opcode);
   assign is_rtype = !is_nop && !is_ill && !is_imm;

   // busy_q is the pre-write-back view, so a release takes effect a cycle later
   assign hazard = instr_valid &&
                   (busy_q[dec.rs1] ||
                    (is_rtype && busy_q[dec.rs2]) ||
                    ((dec.rd != 3'd0) && busy_q[dec.rd]));

   assign instr_ready = rst_n && (!ex_valid_q || ex_ready) && !hazard;
   assign accept      = instr_valid && instr_ready;
   assign issue       = accept && !is_nop && !is_ill;

   regfile #(.DW(DW), .NREG(NREG)) u_regfile (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .raddr1_i (dec.rs1),
      .raddr2_i (dec.rs2),
      .rdata1_o (rdata1),
      .rdata2_o (rdata2),
      .we_i     (wb_en),
      .waddr_i  (wb_rd),
      .wdata_i  (wb_data)
   );

   // Set after clear: a same-cycle issue to the retiring rd keeps it busy
   always_comb begin
      busy_d = busy_q;
      if (wb_en) begin
         busy_d[wb_rd] = 1'b0;
      end
      if (issue && (dec.rd != 3'd0)) begin
         busy_d[dec.rd] = 1'b1;
      end
   end

   always_comb begin
      ex_valid_d   = ex_valid_q;
      ex_aluctrl_d = ex_aluctrl_q;
      ex_din1_d    = ex_din1_q;
      ex_din2_d    = ex_din2_q;
      ex_rd_d      = ex_rd_q;
      if (issue) begin
         ex_valid_d   = 1'b1;
         ex_aluctrl_d = dec.opcode;
         ex_din1_d    = rdata1;
         ex_din2_d    = is_imm ? {{(DW-6){1'b0}}, dec.imm6} : rdata2;
         ex_rd_d      = dec.rd;
      end else if (ex_ready) begin
         ex_valid_d = 1'b0;
      end
   end

   assign illegal_d = accept && is_ill;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q       <= '0;
         ex_valid_q   <= 1'b0;
         ex_aluctrl_q <= '0;
         ex_din1_q    <= '0;
         ex_din2_q    <= '0;
         ex_rd_q      <= '0;
         illegal_q    <= 1'b0;
      end else begin
         busy_q       <= busy_d;
         ex_valid_q   <= ex_valid_d;
         ex_aluctrl_q <= ex_aluctrl_d;
         ex_din1_q    <= ex_din1_d;
         ex_din2_q    <= ex_din2_d;
         ex_rd_q      <= ex_rd_d;
         illegal_q    <= illegal_d;
      end
   end

   assign ex_valid   = ex_valid_q;
   assign ex_aluctrl = ex_aluctrl_q;
   assign ex_din1    = ex_din1_q;
   assign ex_din2    = ex_din2_q;
   assign ex_rd      = ex_rd_q;
   assign illegal    = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage with directed and random stimulus
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = '0;
   logic        ex_valid;
   logic        ex_ready = 1'b0;
   logic [3:0]  ex_aluctrl;
   logic [15:0] ex_din1, ex_din2;
   logic [2:0]  ex_rd;
   logic        wb_en = 1'b0;
   logic [2:0]  wb_rd = '0;
   logic [15:0] wb_data = '0;
   logic        illegal;

   always #5 clk = ~clk;

   id_stage #(.DW(16), .NREG(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_aluctrl(ex_aluctrl),
      .ex_din1(ex_din1), .ex_din2(ex_din2), .ex_rd(ex_rd),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal)
   );

   typedef struct {
      logic [3:0]  alu;
      logic [15:0] d1;
      logic [15:0] d2;
      logic [2:0]  rd;
   } exp_t;

   exp_t        exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          armed   = 1'b0;

   // Architectural view of the machine kept by the bench
   logic [15:0] m_r    [8];
   bit          m_busy [8];
   bit          m_exv;
   bit          m_ill;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
      return {op, rd, rs1, rs2, 3'b000};
   endfunction

   function automatic logic [15:0] read_op(input logic [2:0] a);
      if (a == 3'd0) return 16'h0000;
      if (wb_en && wb_rd == a) return wb_data;
      return m_r[a];
   endfunction

   // Evaluated mid-cycle with inputs stable: check outputs, then advance the model
   task automatic model_step();
      logic [3:0] op;
      logic [2:0] rd, rs1, rs2;
      logic [5:0] imm;
      bit ill, immop, rtype, haz, rdy, acc, iss;
      exp_t e;
      op = instr[15:12]; rd = instr[11:9]; rs1 = instr[8:6]; rs2 = instr[5:3]; imm = instr[5:0];
      ill   = (op == 4'hC) || (op == 4'hD) || (op == 4'hF);
      immop = (op == 4'hB) || (op == 4'hE);
      rtype = !ill && !immop && (op != 4'h0);
      haz   = instr_valid && (m_busy[rs1] || (rtype && m_busy[rs2]) || (rd != 0 && m_busy[rd]));
      rdy   = rst_n && (!m_exv || ex_ready) && !haz;
      if (armed) begin
         chk("instr_ready", instr_ready, rdy);
         chk("ex_valid", ex_valid, m_exv);
         chk("illegal", illegal, m_ill);
      end
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin m_r[i] = '0; m_busy[i] = 0; end
         exp_q.delete();
         m_exv = 0;
         m_ill = 0;
      end else begin
         acc   = instr_valid && rdy;
         iss   = acc && !ill && (op != 4'h0);
         m_ill = acc && ill;
         if (iss) begin
            e.alu = op;
            e.d1  = read_op(rs1);
            e.d2  = immop ? {10'b0, imm} : read_op(rs2);
            e.rd  = rd;
            exp_q.push_back(e);
            m_exv = 1;
         end else if (ex_ready) begin
            m_exv = 0;
         end
         if (wb_en) begin
            if (wb_rd != 0) m_r[wb_rd] = wb_data;
            m_busy[wb_rd] = 0;
         end
         if (iss && rd != 0) m_busy[rd] = 1;
      end
   endtask

   task automatic cycle(input logic rs, input logic v, input logic [15:0] ins, input logic er,
                        input logic we, input logic [2:0] wr, input logic [15:0] wd);
      @(posedge clk);
      #1;
      rst_n = rs; instr_valid = v; instr = ins; ex_ready = er;
      wb_en = we; wb_rd = wr; wb_data = wd;
      @(negedge clk);
      model_step();
   endtask

   // Monitor: every cycle the payload is presented it must match the queue head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (armed && rst_n && ex_valid) begin
            chk("sb_nonempty", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q[0];
               chk("ex_aluctrl", ex_aluctrl, e.alu);
               chk("ex_din1", ex_din1, e.d1);
               chk("ex_din2", ex_din2, e.d2);
               chk("ex_rd", ex_rd, e.rd);
               if (ex_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [2:0]  wr;
      logic [15:0] ins;
      bit          we;
      cycle(0, 0, 0, 1, 0, 0, 0);
      armed = 1'b1;
      cycle(0, 0, 0, 1, 0, 0, 0);
      cycle(1, 0, 0, 1, 0, 0, 0);
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_ex_din1", ex_din1, 0);

      // add r3 = r1 + r2
      cycle(1, 0, 0, 1, 1, 3'd1, 16'd5);
      cycle(1, 0, 0, 1, 1, 3'd2, 16'd3);
      cycle(1, 1, mk(4'h1, 3'd3, 3'd1, 3'd2), 1, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      chk("add_alu", ex_aluctrl, 4'h1);
      chk("add_din1", ex_din1, 16'd5);
      chk("add_din2", ex_din2, 16'd3);
      chk("add_rd", ex_rd, 3'd3);

      // RAW on r3: stalls through the write-back cycle, accepted the cycle after
      repeat (3) cycle(1, 1, mk(4'h2, 3'd4, 3'd3, 3'd0), 1, 0, 0, 0);
      cycle(1, 1, mk(4'h2, 3'd4, 3'd3, 3'd0), 1, 1, 3'd3, 16'd8);
      chk("raw_wb_cycle_ready", instr_ready, 0);
      cycle(1, 1, mk(4'h2, 3'd4, 3'd3, 3'd0), 1, 0, 0, 0);
      chk("raw_accept_ready", instr_ready, 1);
      cycle(1, 0, 0, 0, 0, 0, 0);
      chk("sub_din1", ex_din1, 16'd8);

      // backpressure: payload held, then accepted the cycle ex_ready rises
      repeat (3) cycle(1, 1, mk(4'h1, 3'd5, 3'd1, 3'd2), 0, 0, 0, 0);
      chk("hold_din1", ex_din1, 16'd8);
      cycle(1, 1, mk(4'h1, 3'd5, 3'd1, 3'd2), 1, 0, 0, 0);
      cycle(1, 0, 0, 1, 1, 3'd4, 16'h1234);
      cycle(1, 0, 0, 1, 1, 3'd5, 16'h0042);

      // slli r1 = r2 << 4
      cycle(1, 1, {4'hB, 3'd1, 3'd2, 6'd4}, 1, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      chk("slli_alu", ex_aluctrl, 4'hB);
      chk("slli_din2", ex_din2, 16'h0004);
      cycle(1, 0, 0, 1, 1, 3'd1, 16'h0007);

      // illegal opcode, then write to r0 is discarded
      cycle(1, 1, mk(4'hD, 3'd2, 3'd1, 3'd1), 1, 0, 0, 0);
      cycle(1, 0, 0, 1, 1, 3'd0, 16'hFFFF);
      chk("ill_pulse", illegal, 1);
      cycle(1, 1, mk(4'h1, 3'd6, 3'd0, 3'd0), 1, 0, 0, 0);
      chk("ill_gone", illegal, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      chk("r0_din1", ex_din1, 16'h0000);
      cycle(1, 0, 0, 1, 1, 3'd6, 16'h0000);

      // reset while a payload is held and r3 is busy
      cycle(1, 1, mk(4'h1, 3'd3, 3'd1, 3'd2), 1, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(1, 1, mk(4'h1, 3'd7, 3'd3, 3'd0), 1, 0, 0, 0);
      chk("post_rst_ready", instr_ready, 1);
      cycle(1, 0, 0, 0, 0, 0, 0);
      chk("post_rst_din1", ex_din1, 16'h0000);
      cycle(1, 0, 0, 1, 1, 3'd7, 16'h0000);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         ins = {4'($urandom_range(0, 15)), 12'($urandom())};
         we  = ($urandom_range(0, 2) == 0);
         wr  = 3'($urandom_range(0, 7));
         for (int k = 0; k < 8; k++) begin
            if (!m_busy[wr] && $urandom_range(0, 3) != 0) wr = wr + 3'd1;
         end
         cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), ins,
               ($urandom_range(0, 3) != 0), we, wr, 16'($urandom()));
      end

      repeat (3) cycle(1, 0, 0, 1, 0, 0, 0);
      chk("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
